// File: rtl/sdhci_dat_rx.sv
// SD DAT-line block receiver: start-bit detect, 1/4-bit deserialise,
// per-lane CRC16 (poly 0x1021, init 0, MSB first) and end-bit check.
// Handshake: byte_valid_o is a one-cycle strobe qualifying byte_o; there is
// no ready/backpressure, so the block buffer must take every strobed byte.
module sdhci_dat_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        bus_width_4_i,
    input  logic [11:0] block_len_i,
    input  logic        sample_en_i,
    input  logic [3:0]  dat_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        crc_err_o,
    output logic        end_bit_err_o,
    output logic        timeout_err_o,
    output logic [2:0]  dbg_state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_DATA       = 3'd2,
        S_CRC        = 3'd3,
        S_END        = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           width4_q;
    logic [12:0]    byte_cnt_q;   // bytes still to receive
    logic [2:0]     bit_cnt_q;    // strobes taken within the current byte
    logic [3:0]     crc_cnt_q;
    logic [TW-1:0]  to_cnt_q;
    logic [7:0]     shift_q;
    logic [15:0]    crc_q    [4]; // computed per lane
    logic [15:0]    crc_rx_q [4]; // received per lane

    logic [3:0]     lane_mask;
    logic           start_seen;
    logic           byte_last;
    logic           timeout_hit;
    logic [7:0]     shift_next;
    logic           crc_mismatch;

    function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    assign lane_mask   = width4_q ? 4'hF : 4'h1;
    assign start_seen  = ((dat_i & lane_mask) == 4'h0);
    assign byte_last   = width4_q ? bit_cnt_q[0] : (bit_cnt_q == 3'd7);
    assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign shift_next  = width4_q ? {shift_q[3:0], dat_i} : {shift_q[6:0], dat_i[0]};
    assign dbg_state_o = state_q;

    // Compare received against computed CRC on the lanes in use.
    always_comb begin
        crc_mismatch = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (lane_mask[l] && (crc_rx_q[l] != crc_q[l])) crc_mismatch = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort wins over everything, only strobes advance.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       if (start_i) state_d = S_WAIT_START;
                S_WAIT_START: if (sample_en_i) begin
                                  if (start_seen)       state_d = S_DATA;
                                  else if (timeout_hit) state_d = S_IDLE;
                              end
                S_DATA:       if (sample_en_i && byte_last && (byte_cnt_q == 13'd1)) state_d = S_CRC;
                S_CRC:        if (sample_en_i && (crc_cnt_q == 4'd15)) state_d = S_END;
                S_END:        if (sample_en_i) state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: counters, shift register, CRC lanes, outputs and sticky flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width4_q      <= 1'b0;
            byte_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            crc_cnt_q     <= '0;
            to_cnt_q      <= '0;
            shift_q       <= '0;
            for (int l = 0; l < 4; l++) begin
                crc_q[l]    <= '0;
                crc_rx_q[l] <= '0;
            end
            byte_o        <= '0;
            byte_valid_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            done_o       <= 1'b0;
            if (abort_i) begin
                busy_o    <= 1'b0;
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_i) begin
                        width4_q      <= bus_width_4_i;
                        byte_cnt_q    <= (block_len_i == 12'd0) ? 13'd4096 : {1'b0, block_len_i};
                        bit_cnt_q     <= '0;
                        crc_cnt_q     <= '0;
                        to_cnt_q      <= '0;
                        shift_q       <= '0;
                        for (int l = 0; l < 4; l++) begin
                            crc_q[l]    <= '0;
                            crc_rx_q[l] <= '0;
                        end
                        busy_o        <= 1'b1;
                        crc_err_o     <= 1'b0;
                        end_bit_err_o <= 1'b0;
                        timeout_err_o <= 1'b0;
                    end
                    S_WAIT_START: if (sample_en_i && !start_seen) begin
                        if (timeout_hit) begin
                            timeout_err_o <= 1'b1;
                            done_o        <= 1'b1;
                            busy_o        <= 1'b0;
                        end else begin
                            to_cnt_q <= to_cnt_q + TW'(1);
                        end
                    end
                    S_DATA: if (sample_en_i) begin
                        shift_q <= shift_next;
                        for (int l = 0; l < 4; l++) crc_q[l] <= crc16_next(crc_q[l], dat_i[l]);
                        if (byte_last) begin
                            bit_cnt_q    <= '0;
                            byte_o       <= shift_next;
                            byte_valid_o <= 1'b1;
                            byte_cnt_q   <= byte_cnt_q - 13'd1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    S_CRC: if (sample_en_i) begin
                        for (int l = 0; l < 4; l++) crc_rx_q[l] <= {crc_rx_q[l][14:0], dat_i[l]};
                        crc_cnt_q <= crc_cnt_q + 4'd1;
                    end
                    S_END: if (sample_en_i) begin
                        end_bit_err_o <= |(~dat_i & lane_mask);
                        crc_err_o     <= crc_mismatch;
                        done_o        <= 1'b1;
                        busy_o        <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
